// File: rtl/cache_pkg.sv
// Shared types and constants for the data cache and its load alignment path.
// Access-size codes, FSM state encoding and the narrow-store byte-enable helper.
package cache_pkg;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;

  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE
  } cache_state_t;

  // Byte enables for a store of the given size at the given byte lane.
  function automatic logic [BE_W-1:0] store_be(input logic [1:0] memtype, input logic [1:0] lane);
    logic [BE_W-1:0] be;
    case (memtype)
      MT_BYTE: be = 4'b0001 << lane;
      MT_HALF: be = 4'b0011 << {lane[1], 1'b0};
      default: be = 4'hF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select with sign/zero extension; shared by cached and uncached load paths.
module load_align
  import cache_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0] word_i,
  input  logic [1:0]    lane_i,
  input  logic [1:0]    memtype_i,
  input  logic          memsign_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    case (memtype_i)
      MT_BYTE: data_o = {{(DW-8){memsign_i & byte_sel[7]}}, byte_sel};
      MT_HALF: data_o = {{(DW-16){memsign_i & half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Hits complete in zero cycles; misses and all stores stall the pipeline until RAM acks.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned SETS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic            write_en_i,
  input  logic [DW-1:0]   addr_i,
  input  logic [DW-1:0]   wd_i,
  input  logic [1:0]      memtype_i,
  input  logic            memsign_i,
  output logic [DW-1:0]   rd_o,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wd_o,
  output logic [BE_W-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_rd_i,
  input  logic            mem_ack_i
);

  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned TW = DW - 2 - IW;

  logic [TW-1:0] tag;
  logic [IW-1:0] idx;
  logic [1:0]    lane;

  assign tag  = addr_i[DW-1:IW+2];
  assign idx  = addr_i[IW+1:2];
  assign lane = addr_i[1:0];

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [DW-1:0]   data_q [SETS];

  logic          hit;
  logic [DW-1:0] cached_word;

  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign cached_word = data_q[idx];

  load_align #(.DW(DW)) u_load_align (
    .word_i    (cached_word),
    .lane_i    (lane),
    .memtype_i (memtype_i),
    .memsign_i (memsign_i),
    .data_o    (rd_o)
  );

  // Store data replicated into every lane; byte enables pick the live ones.
  logic [BE_W-1:0] st_be;
  logic [DW-1:0]   st_wd;
  logic [DW-1:0]   merged;

  always_comb begin
    st_be = store_be(memtype_i, lane);
    case (memtype_i)
      MT_BYTE: st_wd = DW'({4{wd_i[7:0]}});
      MT_HALF: st_wd = DW'({2{wd_i[15:0]}});
      default: st_wd = wd_i;
    endcase
    merged = cached_word;
    for (int b = 0; b < 4; b++) begin
      if (st_be[b]) merged[8*b +: 8] = st_wd[8*b +: 8];
    end
  end

  cache_state_t    state_q, state_d;
  logic            done_q, done_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [DW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wd_q, mem_wd_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;
  logic            fill_en;
  logic            merge_en;

  // Next-state, stall and RAM request decode.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_be_d   = mem_be_q;
    stall_o    = 1'b0;
    fill_en    = 1'b0;
    merge_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (!write_en_i) begin
            if (!hit) begin
              stall_o    = 1'b1;
              state_d    = S_FILL;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = {addr_i[DW-1:2], 2'b00};
              mem_be_d   = 4'hF;
            end
          end else if (!done_q) begin
            // A store whose ack just arrived is retired by done_q instead of re-issued.
            stall_o    = 1'b1;
            state_d    = S_WRITE;
            merge_en   = hit;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = {addr_i[DW-1:2], 2'b00};
            mem_wd_d   = st_wd;
            mem_be_d   = st_be;
          end
        end
      end
      S_FILL: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_be_q   <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_be_q   <= mem_be_d;
      if (fill_en) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        tag_q[idx]  <= tag;
        data_q[idx] <= mem_rd_i;
      end else if (merge_en) begin
        data_q[idx] <= merged;
      end
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign mem_be_o   = mem_be_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: RAM responder, abstract cache model and
// a per-cycle compare process, driven by directed load/store vectors.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        write_en_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wd_i = '0;
  logic [1:0]  memtype_i = 2'b10;
  logic        memsign_i = 1'b0;
  logic [31:0] rd_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rd_i = '0;
  logic        mem_ack_i;
  logic        resp_ack = 1'b0;
  logic        late_ack = 1'b0;

  assign mem_ack_i = resp_ack | late_ack;

  data_cache #(.DW(32), .SETS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .write_en_i (write_en_i),
    .addr_i     (addr_i),
    .wd_i       (wd_i),
    .memtype_i  (memtype_i),
    .memsign_i  (memsign_i),
    .rd_o       (rd_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wd_o   (mem_wd_o),
    .mem_be_o   (mem_be_o),
    .mem_rd_i   (mem_rd_i),
    .mem_ack_i  (mem_ack_i)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int ram_lat = 3;
  int cnt = 0;
  bit started = 1'b0;

  logic [31:0] ram [int unsigned];
  bit          mv [64];
  logic [31:0] mtag [64];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a >> 2)) return ram[a >> 2];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] mt, input logic sg);
    logic [31:0] v;
    case (mt)
      2'b00: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (sg && v >= 32'd128) v = v + 32'hFFFFFF00;
      end
      2'b01: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] mt);
    case (mt)
      2'b00:   return 4'(32'd1 << (a % 4));
      2'b01:   return 4'(32'd3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] wd, input logic [1:0] mt);
    case (mt)
      2'b00:   return {24'h0, wd[7:0]} * 32'h01010101;
      2'b01:   return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  // RAM: acks ram_lat cycles after the request is seen, applying writes at ack.
  always @(negedge clk) begin
    if (resp_ack) begin
      resp_ack = 1'b0;
      cnt = 0;
    end else if (!mem_req_o || rst) begin
      cnt = 0;
    end else begin
      cnt++;
      if (cnt >= ram_lat) begin
        resp_ack = 1'b1;
        mem_rd_i = ram_rd(mem_addr_o);
        if (mem_we_o) begin
          logic [31:0] w;
          w = ram_rd(mem_addr_o);
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b]) w[8*b +: 8] = mem_wd_o[8*b +: 8];
          ram[mem_addr_o >> 2] = w;
          wr_count++;
        end
      end
    end
  end

  // Per-cycle comparison against the abstract model.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (!req_i) chk("idle stall", 32'(stall_o), 32'd0);
      if (req_i && !write_en_i && !stall_o)
        chk("load data", rd_o, exp_load(ram_rd(addr_i), addr_i, memtype_i, memsign_i));
      if (mem_req_o) begin
        chk("mem addr", mem_addr_o, addr_i & 32'hFFFFFFFC);
        chk("mem we", 32'(mem_we_o), 32'(write_en_i));
        chk("mem be", 32'(mem_be_o), write_en_i ? 32'(exp_be(addr_i, memtype_i)) : 32'hF);
        if (write_en_i) chk("mem wd", mem_wd_o, exp_wd(wd_i, memtype_i));
      end
    end
  end

  task automatic run(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] mt, input logic sg, input int lat,
                     output int stalls, output logic [31:0] rd,
                     output logic [3:0] be_seen, output logic [31:0] wd_seen);
    int unsigned ix;
    logic [31:0] tg;
    bit hit;
    bit fin;
    int exp_st;
    int w0;
    ix = (a / 4) % 64;
    tg = a / 256;
    hit = mv[ix] && (mtag[ix] == tg);
    exp_st = (we || !hit) ? lat + 1 : 0;
    w0 = wr_count;
    ram_lat = lat;
    stalls = 0;
    rd = '0;
    be_seen = '0;
    wd_seen = '0;
    fin = 1'b0;
    req_i = 1'b1;
    write_en_i = we;
    addr_i = a;
    wd_i = wd;
    memtype_i = mt;
    memsign_i = sg;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!stall_o) begin
        fin = 1'b1;
        break;
      end
      stalls++;
      if (mem_req_o) begin
        be_seen = mem_be_o;
        wd_seen = mem_wd_o;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) chk({nm, " completion timeout"}, 32'd0, 32'd1);
    rd = rd_o;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    write_en_i = 1'b0;
    chk({nm, " stalls"}, 32'(stalls), 32'(exp_st));
    chk({nm, " ram writes"}, 32'(wr_count - w0), we ? 32'd1 : 32'd0);
    if (!we && !hit) begin
      mv[ix] = 1'b1;
      mtag[ix] = tg;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int st;
  logic [31:0] rd;
  logic [3:0]  be;
  logic [31:0] wdv;
  bit          seen;

  initial begin
    ram[32'h100 >> 2] = 32'hDEADBEEF;
    ram[32'h200 >> 2] = 32'h12345678;
    ram[32'h300 >> 2] = 32'hCAFEF00D;
    for (int i = 0; i < 64; i++) begin
      mv[i] = 1'b0;
      mtag[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset mem_req", 32'(mem_req_o), 32'd0);
    chk("reset mem_we", 32'(mem_we_o), 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    idle(1);

    run("cold lw", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, st, rd, be, wdv);
    chk("cold lw stall lit", 32'(st), 32'd4);
    chk("cold lw data lit", rd, 32'hDEADBEEF);
    run("repeat lw", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, st, rd, be, wdv);
    chk("repeat lw stall lit", 32'(st), 32'd0);

    run("sw hit", 1'b1, 32'h100, 32'h80FF7F01, 2'b10, 1'b0, 2, st, rd, be, wdv);
    chk("sw hit be lit", 32'(be), 32'hF);
    idle(1);
    run("lb", 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 2, st, rd, be, wdv);
    chk("lb lit", rd, 32'hFFFFFF80);
    run("lbu", 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 2, st, rd, be, wdv);
    chk("lbu lit", rd, 32'h00000080);
    run("lh", 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 2, st, rd, be, wdv);
    chk("lh lit", rd, 32'hFFFF80FF);
    run("lhu low", 1'b0, 32'h100, 32'h0, 2'b01, 1'b0, 2, st, rd, be, wdv);
    chk("lhu low lit", rd, 32'h00007F01);
    run("lb low", 1'b0, 32'h100, 32'h0, 2'b00, 1'b1, 2, st, rd, be, wdv);
    chk("lb low lit", rd, 32'h00000001);

    run("sb hit", 1'b1, 32'h101, 32'h123456AA, 2'b00, 1'b0, 1, st, rd, be, wdv);
    chk("sb be lit", 32'(be), 32'h2);
    chk("sb wd lit", wdv, 32'hAAAAAAAA);
    chk("sb stall lit", 32'(st), 32'd2);
    run("lw after sb", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, st, rd, be, wdv);
    chk("lw after sb lit", rd, 32'h80FFAA01);
    run("sh hit", 1'b1, 32'h102, 32'h0000C0DE, 2'b01, 1'b0, 2, st, rd, be, wdv);
    chk("sh be lit", 32'(be), 32'hC);
    chk("sh wd lit", wdv, 32'hC0DEC0DE);
    run("lw after sh", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, st, rd, be, wdv);
    chk("lw after sh lit", rd, 32'hC0DEAA01);

    run("sw miss", 1'b1, 32'h200, 32'h55667788, 2'b10, 1'b0, 2, st, rd, be, wdv);
    chk("sw miss be lit", 32'(be), 32'hF);
    run("lw line kept", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 2, st, rd, be, wdv);
    chk("lw line kept stall lit", 32'(st), 32'd0);
    run("lw conflict", 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 2, st, rd, be, wdv);
    chk("lw conflict stall lit", 32'(st), 32'd3);
    chk("lw conflict data lit", rd, 32'h55667788);
    run("lw reload", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, st, rd, be, wdv);
    chk("lw reload stall lit", 32'(st), 32'd2);
    run("lw misaligned", 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 1, st, rd, be, wdv);
    chk("lw misaligned lit", rd, 32'hC0DEAA01);

    // Reset while a fill is outstanding, then a stray ack in idle.
    ram_lat = 100;
    req_i = 1'b1;
    write_en_i = 1'b0;
    addr_i = 32'h300;
    memtype_i = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fill started", 32'(seen), 32'd1);
    chk("fill stall", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_i = 1'b0;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    @(negedge clk);
    chk("rst mid-fill mem_req", 32'(mem_req_o), 32'd0);
    @(posedge clk);
    #1;
    late_ack = 1'b1;
    mem_rd_i = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    @(negedge clk);
    chk("late ack mem_req", 32'(mem_req_o), 32'd0);
    idle(1);
    run("lw after rst", 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 2, st, rd, be, wdv);
    chk("lw after rst stall lit", 32'(st), 32'd3);
    chk("lw after rst data lit", rd, 32'hCAFEF00D);
    run("lw 100 after rst", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, st, rd, be, wdv);
    chk("lw 100 after rst stall lit", 32'(st), 32'd2);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
